// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator car controller.
package elev_pkg;

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
   typedef enum logic {UP, DOWN} dir_t;

   function automatic int floor_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/elev_call_reg.sv
// Pending-call bank: sticky set per floor, clear on door entry.
// Also splits pending calls into ahead/behind of the car for the current direction.
module elev_call_reg
   import elev_pkg::*;
#(
   parameter int FLOORS  = 4,
   parameter int FLOOR_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FLOORS-1:0]  set,
   input  logic [FLOORS-1:0]  clr,
   input  logic [FLOOR_W-1:0] floor,
   input  dir_t               dir,
   output logic [FLOORS-1:0]  pending,
   output logic [FLOORS-1:0]  ahead,
   output logic [FLOORS-1:0]  behind
);

   // Clear has priority so a press on the entry edge does not re-arm the stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending | set) & ~clr;
   end

   always_comb begin
      ahead  = '0;
      behind = '0;
      for (int f = 0; f < FLOORS; f++) begin
         if (f > int'(floor)) begin
            if (dir == UP) ahead[f]  = pending[f];
            else           behind[f] = pending[f];
         end else if (f < int'(floor)) begin
            if (dir == UP) behind[f] = pending[f];
            else           ahead[f]  = pending[f];
         end
      end
   end

endmodule

// File: rtl/elev_sched_ctrl.sv
// SCAN elevator scheduler: call latch, motor/door sequencing with travel and dwell timers.
// Optional emergency stop (freezes the car in place) built with ELEV_ESTOP_EN.
module elev_sched_ctrl
   import elev_pkg::*;
#(
   parameter int FLOORS     = 4,
   parameter int TRAVEL_CYC = 8,
   parameter int DOOR_CYC   = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
`ifdef ELEV_ESTOP_EN
   input  logic                        estop_i,
`endif
   input  logic [FLOORS-1:0]           req_i,
   output logic [floor_w(FLOORS)-1:0]  floor_o,
   output logic                        motor_up_o,
   output logic                        motor_dn_o,
   output logic                        door_open_o,
   output logic [FLOORS-1:0]           pending_o,
   output logic                        busy_o
);

   localparam int FLOOR_W = floor_w(FLOORS);
   localparam int TW      = $clog2(TRAVEL_CYC);
   localparam int DW      = $clog2(DOOR_CYC);

   state_t              state, state_nxt;
   dir_t                dir, dir_nxt;
   logic [FLOOR_W-1:0]  floor_nxt, nf;
   logic [TW-1:0]       travel_cnt, travel_nxt;
   logic [DW-1:0]       dwell_cnt, dwell_nxt;
   logic [FLOORS-1:0]   here, nf_hot, set, clr, ahead, behind;

   assign here   = FLOORS'(1) << floor_o;
   assign nf     = (dir == UP) ? floor_o + FLOOR_W'(1) : floor_o - FLOOR_W'(1);
   assign nf_hot = FLOORS'(1) << nf;

   // A press for the open floor only extends the dwell; it never queues a call.
`ifdef ELEV_ESTOP_EN
   assign set = estop_i ? '0 : (req_i & ~((state == DOOR) ? here : '0));
`else
   assign set = req_i & ~((state == DOOR) ? here : '0);
`endif

   elev_call_reg #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_calls (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (set),
      .clr     (clr),
      .floor   (floor_o),
      .dir     (dir),
      .pending (pending_o),
      .ahead   (ahead),
      .behind  (behind)
   );

   always_comb begin
      state_nxt  = state;
      dir_nxt    = dir;
      floor_nxt  = floor_o;
      travel_nxt = travel_cnt;
      dwell_nxt  = dwell_cnt;
      clr        = '0;
      case (state)
         IDLE: begin
            travel_nxt = '0;
            if (|pending_o) begin
               if (|(pending_o & here)) begin
                  state_nxt = DOOR;
                  clr       = here;
                  dwell_nxt = '0;
               end else begin
                  state_nxt = MOVE;
                  if (!(|ahead)) dir_nxt = (dir == UP) ? DOWN : UP;
               end
            end
         end
         MOVE: begin
            if (travel_cnt == TW'(TRAVEL_CYC - 1)) begin
               travel_nxt = '0;
               floor_nxt  = nf;
               // Masks are relative to the floor being left, so re-base them on nf.
               if (|(pending_o & nf_hot)) begin
                  state_nxt = DOOR;
                  clr       = nf_hot;
                  dwell_nxt = '0;
               end else if (|(ahead & ~nf_hot)) begin
                  state_nxt = MOVE;
               end else if (|(behind | (pending_o & here))) begin
                  dir_nxt   = (dir == UP) ? DOWN : UP;
               end else begin
                  state_nxt = IDLE;
               end
               if (nf == FLOOR_W'(FLOORS - 1)) dir_nxt = DOWN;
               if (nf == '0)                   dir_nxt = UP;
            end else begin
               travel_nxt = travel_cnt + TW'(1);
            end
         end
         DOOR: begin
            if (|(req_i & here)) begin
               dwell_nxt = '0;
            end else if (dwell_cnt == DW'(DOOR_CYC - 1)) begin
               state_nxt = IDLE;
               dwell_nxt = '0;
            end else begin
               dwell_nxt = dwell_cnt + DW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
`ifdef ELEV_ESTOP_EN
      if (estop_i) begin
         state_nxt  = state;
         dir_nxt    = dir;
         floor_nxt  = floor_o;
         travel_nxt = travel_cnt;
         dwell_nxt  = dwell_cnt;
         clr        = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dir         <= UP;
         floor_o     <= '0;
         travel_cnt  <= '0;
         dwell_cnt   <= '0;
         motor_up_o  <= 1'b0;
         motor_dn_o  <= 1'b0;
         door_open_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state       <= state_nxt;
         dir         <= dir_nxt;
         floor_o     <= floor_nxt;
         travel_cnt  <= travel_nxt;
         dwell_cnt   <= dwell_nxt;
         busy_o      <= (state_nxt != IDLE);
`ifdef ELEV_ESTOP_EN
         motor_up_o  <= !estop_i && (state == MOVE) && (dir == UP);
         motor_dn_o  <= !estop_i && (state == MOVE) && (dir == DOWN);
         door_open_o <= estop_i ? door_open_o : (state == DOOR);
`else
         motor_up_o  <= (state == MOVE) && (dir == UP);
         motor_dn_o  <= (state == MOVE) && (dir == DOWN);
         door_open_o <= (state == DOOR);
`endif
      end
   end

endmodule

// File: tb/tb_elev_sched_ctrl.sv
// Directed bench for elev_sched_ctrl (FLOORS=4, TRAVEL_CYC=8, DOOR_CYC=6).
module tb_elev_sched_ctrl;

   logic       clk, rst_n;
   logic [3:0] req;
   logic [1:0] floor;
   logic       up, dn, door, busy;
   logic [3:0] pend;
`ifdef ELEV_ESTOP_EN
   logic       estop;
`endif

   int n_chk, n_fail, cyc;
   int up_cnt, dn_cnt, door_cnt, ovl, dn_early, nd, last_door;
   int f1, f2, f3, first_door;
   int dfl[3];
   logic prev_door;

   elev_sched_ctrl #(.FLOORS(4), .TRAVEL_CYC(8), .DOOR_CYC(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef ELEV_ESTOP_EN
      .estop_i     (estop),
`endif
      .req_i       (req),
      .floor_o     (floor),
      .motor_up_o  (up),
      .motor_dn_o  (dn),
      .door_open_o (door),
      .pending_o   (pend),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clr_stats();
      up_cnt = 0; dn_cnt = 0; door_cnt = 0; ovl = 0; dn_early = 0; nd = 0;
      f1 = -1; f2 = -1; f3 = -1; first_door = -1; last_door = -1;
      prev_door = door;
   endtask

   task automatic observe();
      if (up) up_cnt++;
      if (dn) dn_cnt++;
      if (door) begin
         door_cnt++;
         last_door = cyc;
      end
      if ((up && dn) || ((up || dn) && door)) ovl++;
      if (dn && nd < 2) dn_early++;
      if (floor == 2'd1 && f1 < 0) f1 = cyc;
      if (floor == 2'd2 && f2 < 0) f2 = cyc;
      if (floor == 2'd3 && f3 < 0) f3 = cyc;
      if (door && !prev_door) begin
         if (first_door < 0) first_door = cyc;
         if (nd < 3) dfl[nd] = int'(floor);
         nd++;
      end
      prev_door = door;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0;
      req = '0;
`ifdef ELEV_ESTOP_EN
      estop = 1'b0;
`endif
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      check("rst_floor", int'(floor), 0);
      check("rst_motor", int'({up, dn}), 0);
      check("rst_door",  int'(door), 0);
      check("rst_busy",  int'(busy), 0);
      check("rst_pend",  int'(pend), 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Same-floor call at floor 0
      req = 4'b0001; cyc = 0;
      step(); req = '0;
      check("t1_pend_set", int'(pend), 1);
      step();
      check("t1_pend_clr_at_entry", int'(pend), 0);
      check("t1_door_not_yet", int'(door), 0);
      check("t1_busy", int'(busy), 1);
      step();
      check("t1_door_at_n2", int'(door), 1);
      door_cnt = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (door) door_cnt++;
      end
      check("t1_door_len", door_cnt, 6);
      check("t1_idle", int'(busy), 0);

      // Travel 0 -> 3
      req = 4'b1000; cyc = 0;
      step(); req = '0;
      clr_stats();
      for (int i = 0; i < 44; i++) begin
         step();
         observe();
      end
      check("t2_up_cycles", up_cnt, 24);
      check("t2_dn_cycles", dn_cnt, 0);
      check("t2_floor1_at", f1, 10);
      check("t2_floor2_at", f2, 18);
      check("t2_floor3_at", f3, 26);
      check("t2_door_at", first_door, 27);
      check("t2_door_len", door_cnt, 6);
      check("t2_overlap", ovl, 0);
      check("t2_final_floor", int'(floor), 3);

      // Dwell restart at floor 2
      req = 4'b0100; cyc = 0;
      step(); req = '0;
      repeat (13) step();
      check("t3_at_floor2", int'(floor), 2);
      check("t3_door_open", int'(door), 1);
      req = 4'b0100;
      step(); req = '0;
      check("t3_pend_not_latched", int'(pend), 0);
      clr_stats();
      for (int i = 0; i < 15; i++) begin
         step();
         observe();
      end
      check("t3_door_extra", door_cnt, 6);
      check("t3_door_last", last_door, 21);
      check("t3_pend_after", int'(pend), 0);

      // Asynchronous reset mid-move (floor 2 -> 0, timer 3)
      req = 4'b0001; cyc = 0;
      step(); req = '0;
      repeat (4) step();
      check("t4_moving_dn", int'(dn), 1);
      check("t4_pend_before", int'(pend), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t4_rst_floor", int'(floor), 0);
      check("t4_rst_motor", int'({up, dn}), 0);
      check("t4_rst_busy", int'(busy), 0);
      check("t4_rst_pend", int'(pend), 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // SCAN: going up to 3, calls for 0 and 2 appear past floor 1
      req = 4'b1000; cyc = 0;
      step(); req = '0;
      clr_stats();
      for (int i = 0; i < 74; i++) begin
         step();
         observe();
         if (cyc == 11) begin
            check("t5_past_floor1", int'(floor), 1);
            req = 4'b0101;
         end
         if (cyc == 12) begin
            req = '0;
            check("t5_pend", int'(pend), 13);
         end
      end
      check("t5_stops", nd, 3);
      check("t5_stop0", dfl[0], 2);
      check("t5_stop1", dfl[1], 3);
      check("t5_stop2", dfl[2], 0);
      check("t5_up_cycles", up_cnt, 24);
      check("t5_dn_cycles", dn_cnt, 24);
      check("t5_dn_before_reverse", dn_early, 0);
      check("t5_door_len", door_cnt, 18);
      check("t5_overlap", ovl, 0);
      check("t5_final_pend", int'(pend), 0);
      check("t5_final_busy", int'(busy), 0);

`ifdef ELEV_ESTOP_EN
      // Emergency stop mid-move 0 -> 1
      req = 4'b0010; cyc = 0;
      step(); req = '0;
      clr_stats();
      for (int i = 0; i < 4; i++) begin
         step();
         observe();
      end
      check("t6_moving", int'(up), 1);
      estop = 1'b1;
      up_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (up) up_cnt++;
         if (floor != 2'd0) f1 = cyc;
      end
      check("t6_motor_frozen", up_cnt, 0);
      check("t6_floor_held", f1, -1);
      estop = 1'b0;
      up_cnt = 3;
      for (int i = 0; i < 20; i++) begin
         step();
         if (up) up_cnt++;
      end
      check("t6_up_total", up_cnt, 8);
      check("t6_arrived", int'(floor), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/elev_sched_ctrl.md
Name: elev_sched_ctrl

Overview:
- Car controller and request scheduler for the elevator. Latches floor-call buttons from all floors and serves them with a SCAN policy: keep the current direction while calls remain ahead, otherwise reverse.
- Sequences the motor (up/down) and the door, with cycle-counted travel and dwell timers.
- Sits between the button/flip-flop input stage and the motor/door/display outputs.

Parameters:
- FLOORS, 4, number of floors (2..16); floors are numbered 0..FLOORS-1.
- TRAVEL_CYC, 8, clock cycles of motion per one-floor move (>=2).
- DOOR_CYC, 6, clock cycles the door stays open per stop (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_i  in  FLOORS  call buttons, one bit per floor, level or pulse; sampled every cycle.
- floor_o  out  FLOOR_W  current floor, binary; FLOOR_W = clog2(FLOORS).
- motor_up_o  out  1  drive car up.
- motor_dn_o  out  1  drive car down.
- door_open_o  out  1  door open.
- pending_o  out  FLOORS  latched, not-yet-served calls.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) applies immediately, including mid-move or mid-dwell:
  - state=IDLE, floor_o=0, dir=UP, pending_o=0.
  - All motor, door and busy outputs 0; both timers 0.
- All outputs are registered.
- Call latch: pending[f] <= pending[f] | req_i[f] each cycle.
  - pending[f] clears only on the edge that enters DOOR at floor f.
  - req_i[floor_o] while in DOOR is not latched; it restarts the dwell timer instead.
- States:
  - IDLE: if pending==0, stay.
    - Else if pending[floor], go to DOOR.
    - Else if calls exist ahead in dir, go to MOVE.
    - Else flip dir and go to MOVE.
  - MOVE: motor_up_o=(dir==UP), motor_dn_o=(dir==DOWN). The travel timer counts 0..TRAVEL_CYC-1. At terminal count:
    - floor_o updates by ±1 and the timer resets.
    - If pending[new floor], go to DOOR (clear the bit).
    - Else if calls remain ahead, stay in MOVE.
    - Else if calls remain behind, flip dir and stay in MOVE.
    - Else go to IDLE.
  - DOOR: door_open_o=1 and the dwell timer counts 0..DOOR_CYC-1. At terminal count, go to IDLE.
- Latency: req_i sampled at edge n for the current floor while in IDLE gives door_open_o high from edge n+2, for exactly DOOR_CYC cycles.
- Motor and door are never active together. motor_up_o and motor_dn_o are mutually exclusive.
- Boundaries:
  - dir is forced DOWN at FLOORS-1 and UP at 0.
  - floor_o never wraps; an out-of-range move is impossible by construction.
- Simultaneous calls ahead and behind: the ahead calls win (SCAN). From IDLE with equal candidates, keep the previous dir.
- A call for a floor the car is traveling toward, arriving during MOVE, is honored at arrival if latched before the terminal-count edge.
- The "calls ahead/behind" masks are computed combinationally from pending and floor_o.

Optional Feature:
- Macro: ELEV_ESTOP_EN.
- When defined, adds input estop_i (1 bit, active-high):
  - While estop_i=1: motor outputs are forced 0 and the travel timer freezes; floor_o and pending are held; door_open_o stays at its current value.
  - When estop_i returns to 0: the car resumes from the frozen count.
  - estop_i in IDLE blocks departure.
- When undefined: no port and no gating logic.

Decomposition:
- Package elev_pkg:
  - state enum {IDLE, MOVE, DOOR}.
  - dir enum {UP, DOWN}.
  - Function floor_w(FLOORS) returning the clog2 width.
- Sub-module elev_call_reg: the pending-call bank with set/clear. Outputs pending plus ahead/behind masks given floor_o and dir. The FSM and timers stay in elev_sched_ctrl.

Test Plan:
- Reset mid-move: rst_n low during MOVE at timer=3 → outputs 0, floor_o=0, pending 0 in the same cycle, without waiting for a clock edge.
- Same-floor call: IDLE at floor 0, req_i=4'b0001 one cycle → door_open_o high 2 cycles later for 6 cycles, then IDLE; pending_o[0]=0 at door entry.
- Travel: req floor 3 from 0 → motor_up_o high 24 cycles, floor_o 1,2,3 every 8 cycles, door opens at 3, motor low during door.
- SCAN: moving up past floor 1, req floors 0 and 2 → stop at 2, continue to 3 if pending, then reverse and stop at 0; motor_dn_o only after reversal.
- Dwell restart: in DOOR at floor 2 with dwell=4, pulse req_i[2] → door stays open a further 6 cycles; pending_o[2] stays 0.
- ELEV_ESTOP_EN: estop_i=1 for 10 cycles mid-MOVE → motors 0, floor_o held; after release the move completes with TRAVEL_CYC total active cycles.
